// File: rtl/en_ext_mem_port_pkg.sv
// Shared types for the ElectronNest external-memory port: tokens, widths and FSM states.
package en_ext_mem_port_pkg;

  localparam int unsigned WIDTH_DATA   = 32;
  localparam int unsigned WIDTH_EXADDR = 16;

  typedef struct packed {
    logic                    v;
    logic                    a;
    logic                    r;
    logic                    c;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0]   d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic c;
  } BTk_t;

  typedef enum logic [1:0] {
    StIdle,
    StBootPad,
    StBootData,
    StServe
  } en_extmem_st_t;

  function automatic logic addr_ok(logic [WIDTH_EXADDR-1:0] addr, int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/en_ext_mem_port_if.sv
// Host/consumer-facing bus of the external-memory port; slave = memory side.
interface en_ext_mem_port_if;
  import en_ext_mem_port_pkg::*;

  logic                    I_Init_We;
  logic [WIDTH_EXADDR-1:0] I_Init_Addr;
  logic [WIDTH_DATA-1:0]   I_Init_Data;
  logic                    I_Boot;
  logic                    O_Busy;
  logic                    I_Ld_Req;
  logic [WIDTH_EXADDR-1:0] I_Ld_Addr;
  FTk_t                    O_Ld_FTk;
  BTk_t                    I_Ld_BTk;
  logic                    I_St_Req;
  logic [WIDTH_EXADDR-1:0] I_St_Addr;
  FTk_t                    I_St_FTk;
  BTk_t                    O_St_BTk;
  logic                    O_Err;
  logic [31:0]             O_Ld_Cnt;
  logic [31:0]             O_St_Cnt;

  modport slave (
    input  I_Init_We, I_Init_Addr, I_Init_Data, I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk,
    input  I_St_Req, I_St_Addr, I_St_FTk,
    output O_Busy, O_Ld_FTk, O_St_BTk, O_Err, O_Ld_Cnt, O_St_Cnt
  );

  modport master (
    output I_Init_We, I_Init_Addr, I_Init_Data, I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk,
    output I_St_Req, I_St_Addr, I_St_FTk,
    input  O_Busy, O_Ld_FTk, O_St_BTk, O_Err, O_Ld_Cnt, O_St_Cnt
  );

endinterface

// File: rtl/en_ext_mem_port_rdpipe.sv
// Stall-able read-response shift pipeline; freeze holds every stage including the output.
module en_ext_mem_rdpipe
  import en_ext_mem_port_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    freeze_i,
  input  logic                    in_v_i,
  input  logic [WIDTH_DATA-1:0]   in_d_i,
  input  logic [WIDTH_EXADDR-1:0] in_i_i,
  output logic                    out_v_o,
  output logic [WIDTH_DATA-1:0]   out_d_o,
  output logic [WIDTH_EXADDR-1:0] out_i_o
);

  logic [RD_LAT-1:0]       v_q, v_d;
  logic [WIDTH_DATA-1:0]   d_q [RD_LAT];
  logic [WIDTH_DATA-1:0]   d_d [RD_LAT];
  logic [WIDTH_EXADDR-1:0] i_q [RD_LAT];
  logic [WIDTH_EXADDR-1:0] i_d [RD_LAT];

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    if (!freeze_i) begin
      // Bubbles carry zero payload so an idle output reads as an all-zero token.
      v_d[0] = in_v_i;
      d_d[0] = in_v_i ? in_d_i : '0;
      i_d[0] = in_v_i ? in_i_i : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        v_d[s] = v_q[s-1];
        d_d[s] = d_q[s-1];
        i_d[s] = i_q[s-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        d_q[s] <= '0;
        i_q[s] <= '0;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
    end
  end

  assign out_v_o = v_q[RD_LAT-1];
  assign out_d_o = d_q[RD_LAT-1];
  assign out_i_o = i_q[RD_LAT-1];

endmodule

// File: rtl/en_ext_mem_port.sv
// External-memory port: host preload, boot stream onto the Ld channel, then pipelined loads/stores.
module en_ext_mem_port
  import en_ext_mem_port_pkg::*;
#(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned BOOT_PAD   = 3,
  parameter int unsigned BOOT_WORDS = 5,
  parameter bit          EXTEND_MEM = 1'b0
) (
  input logic              clock,
  input logic              reset,
  en_ext_mem_port_if.slave bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LastPad  = 32'(BOOT_PAD - 1);
  localparam logic [31:0] LastWord = 32'(BOOT_WORDS - 1);

  en_extmem_st_t         state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [31:0]           ld_cnt_q, ld_cnt_d;
  logic [31:0]           st_cnt_q, st_cnt_d;
  logic [WIDTH_DATA-1:0] mem_q [DEPTH];

  logic                    in_boot, serve;
  logic                    ld_acc, ld_ok;
  logic                    st_btk_n, st_fire, st_ok, st_commit;
  logic [WIDTH_DATA-1:0]   rd_data;
  logic [WIDTH_EXADDR-1:0] ld_idx;
  FTk_t                    boot_tk, pipe_tk;
  logic                    pipe_v;
  logic [WIDTH_DATA-1:0]   pipe_d;
  logic [WIDTH_EXADDR-1:0] pipe_i;
  logic                    unused_bits;

  assign in_boot   = (state_q == StBootPad) || (state_q == StBootData);
  assign serve     = (state_q == StServe);
  assign ld_acc    = serve & bus.I_Ld_Req & ~bus.I_Ld_BTk.n;
  assign ld_ok     = addr_ok(bus.I_Ld_Addr, DEPTH);
  assign rd_data   = ld_ok ? mem_q[bus.I_Ld_Addr[AW-1:0]] : '0;
  assign ld_idx    = EXTEND_MEM ? bus.I_Ld_Addr : '0;
  assign st_btk_n  = ~serve | bus.I_Init_We;
  assign st_fire   = bus.I_St_Req & bus.I_St_FTk.v & ~st_btk_n;
  assign st_ok     = addr_ok(bus.I_St_Addr, DEPTH);
  assign st_commit = st_fire & st_ok;

  // Load data is read combinationally before this edge's write: read-before-write on collision.
  always_ff @(posedge clock) begin
    if (bus.I_Init_We && addr_ok(bus.I_Init_Addr, DEPTH)) begin
      mem_q[bus.I_Init_Addr[AW-1:0]] <= bus.I_Init_Data;
    end else if (st_commit) begin
      mem_q[bus.I_St_Addr[AW-1:0]] <= bus.I_St_FTk.d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    boot_tk  = '0;
    err_d    = err_q | (ld_acc & ~ld_ok) | (st_fire & ~st_ok);
    ld_cnt_d = ld_cnt_q + 32'(ld_acc);
    st_cnt_d = st_cnt_q + 32'(st_commit);
    unique case (state_q)
      StIdle: begin
        if (bus.I_Boot) begin
          state_d = (BOOT_PAD > 0) ? StBootPad : StBootData;
          cnt_d   = '0;
        end
      end
      StBootPad: begin
        boot_tk.v = 1'b1;
        boot_tk.a = (cnt_q == '0);
        if (cnt_q == LastPad) begin
          state_d = StBootData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StBootData: begin
        boot_tk.v = 1'b1;
        boot_tk.a = (BOOT_PAD == 0) && (cnt_q == '0);
        boot_tk.d = mem_q[cnt_q[AW-1:0]];
        if (cnt_q == LastWord) begin
          state_d = StServe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StServe: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  en_ext_mem_rdpipe #(
    .RD_LAT(RD_LAT)
  ) u_rdpipe (
    .clock   (clock),
    .reset   (reset),
    .freeze_i(bus.I_Ld_BTk.n),
    .in_v_i  (ld_acc),
    .in_d_i  (rd_data),
    .in_i_i  (ld_idx),
    .out_v_o (pipe_v),
    .out_d_o (pipe_d),
    .out_i_o (pipe_i)
  );

  assign pipe_tk      = '{v: pipe_v, a: 1'b0, r: 1'b0, c: 1'b0, i: pipe_i, d: pipe_d};
  assign bus.O_Ld_FTk = in_boot ? boot_tk : pipe_tk;
  assign bus.O_St_BTk = '{n: st_btk_n, t: 1'b0, c: 1'b0};
  assign bus.O_Busy   = in_boot;
  assign bus.O_Err    = err_q;
  assign bus.O_Ld_Cnt = ld_cnt_q;
  assign bus.O_St_Cnt = st_cnt_q;

  assign unused_bits = ^{bus.I_Ld_BTk.t, bus.I_Ld_BTk.c, bus.I_St_FTk.a, bus.I_St_FTk.r,
                         bus.I_St_FTk.c, bus.I_St_FTk.i};

endmodule

// File: tb/tb_en_ext_mem_port.sv
// Self-checking bench for en_ext_mem_port: boot vector table, directed corners, random traffic.
module tb_en_ext_mem_port;
  import en_ext_mem_port_pkg::*;

  localparam int unsigned DEPTH      = 2048;
  localparam int unsigned RD_LAT     = 3;
  localparam int unsigned BOOT_PAD   = 3;
  localparam int unsigned BOOT_WORDS = 5;
  localparam bit          EXTEND_MEM = 1'b1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  en_ext_mem_port_if bus ();

  en_ext_mem_port #(
    .DEPTH     (DEPTH),
    .RD_LAT    (RD_LAT),
    .BOOT_PAD  (BOOT_PAD),
    .BOOT_WORDS(BOOT_WORDS),
    .EXTEND_MEM(EXTEND_MEM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: memory image, responses tagged with the un-stalled cycle they are due.
  typedef struct {
    int   due;
    FTk_t tk;
  } pend_t;

  logic [31:0] mdl_mem [DEPTH];
  pend_t       pend_q[$];
  int          tick = 0;
  logic        mdl_err = 1'b0;
  logic [31:0] mdl_ld_cnt = '0;
  logic [31:0] mdl_st_cnt = '0;

  typedef struct {
    logic        boot;
    logic        ld_req;
    logic        btk_n;
    logic        st_req;
    logic        exp_v;
    logic        exp_a;
    logic        exp_busy;
    logic        exp_stn;
    logic [31:0] exp_d;
  } boot_vec_t;

  boot_vec_t bt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic FTk_t exp_tok();
    FTk_t t = '0;
    while (pend_q.size() > 0 && pend_q[0].due < tick) void'(pend_q.pop_front());
    foreach (pend_q[k]) if (pend_q[k].due == tick) t = pend_q[k].tk;
    return t;
  endfunction

  task automatic drive_idle();
    bus.I_Init_We   = 1'b0;
    bus.I_Init_Addr = '0;
    bus.I_Init_Data = '0;
    bus.I_Boot      = 1'b0;
    bus.I_Ld_Req    = 1'b0;
    bus.I_Ld_Addr   = '0;
    bus.I_Ld_BTk    = '0;
    bus.I_St_Req    = 1'b0;
    bus.I_St_Addr   = '0;
    bus.I_St_FTk    = '0;
  endtask

  task automatic init_wr(input logic [15:0] addr, input logic [31:0] data);
    bus.I_Init_We   = 1'b1;
    bus.I_Init_Addr = addr;
    bus.I_Init_Data = data;
    mdl_mem[addr[10:0]] = data;
    @(posedge clock);
    #1;
    bus.I_Init_We = 1'b0;
  endtask

  // One SERVE-state cycle: drive, compare against the model, advance the model, cross the edge.
  task automatic cyc(input logic ld_req, input logic [15:0] ld_addr, input logic btk_n,
                     input logic st_req, input logic st_v, input logic [15:0] st_addr,
                     input logic [31:0] st_d, input logic iw, input logic [15:0] ia,
                     input logic [31:0] id);
    FTk_t e;
    FTk_t s;
    BTk_t b;
    b = '0;
    b.n = btk_n;
    s = '0;
    s.v = st_v;
    s.d = st_d;
    bus.I_Ld_Req    = ld_req;
    bus.I_Ld_Addr   = ld_addr;
    bus.I_Ld_BTk    = b;
    bus.I_St_Req    = st_req;
    bus.I_St_Addr   = st_addr;
    bus.I_St_FTk    = s;
    bus.I_Init_We   = iw;
    bus.I_Init_Addr = ia;
    bus.I_Init_Data = id;
    #1;
    e = exp_tok();
    if (e.v) chk("ld_tok", 64'(bus.O_Ld_FTk), 64'(e));
    else chk("ld_v_idle", 64'(bus.O_Ld_FTk.v), 64'd0);
    chk("st_btk", 64'(bus.O_St_BTk), 64'({iw, 2'b00}));
    chk("err", 64'(bus.O_Err), 64'(mdl_err));
    chk("ld_cnt", 64'(bus.O_Ld_Cnt), 64'(mdl_ld_cnt));
    chk("st_cnt", 64'(bus.O_St_Cnt), 64'(mdl_st_cnt));
    if (ld_req && !btk_n) begin
      e = '0;
      e.v = 1'b1;
      if (32'(ld_addr) < DEPTH) e.d = mdl_mem[ld_addr[10:0]];
      else mdl_err = 1'b1;
      if (EXTEND_MEM) e.i = ld_addr;
      pend_q.push_back('{due: tick + int'(RD_LAT), tk: e});
      mdl_ld_cnt++;
    end
    if (st_req && st_v && !iw) begin
      if (32'(st_addr) < DEPTH) begin
        mdl_mem[st_addr[10:0]] = st_d;
        mdl_st_cnt++;
      end else begin
        mdl_err = 1'b1;
      end
    end
    if (iw && 32'(ia) < DEPTH) mdl_mem[ia[10:0]] = id;
    if (!btk_n) tick++;
    @(posedge clock);
    #1;
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic ld(input logic [15:0] a, input logic btk_n);
    cyc(1'b1, a, btk_n, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ldtk"}, 64'(bus.O_Ld_FTk), 64'd0);
    chk({tag, "_stbtk"}, 64'(bus.O_St_BTk), 64'(3'b100));
    chk({tag, "_busy"}, 64'(bus.O_Busy), 64'd0);
    chk({tag, "_err"}, 64'(bus.O_Err), 64'd0);
    chk({tag, "_ldcnt"}, 64'(bus.O_Ld_Cnt), 64'd0);
    chk({tag, "_stcnt"}, 64'(bus.O_St_Cnt), 64'd0);
  endtask

  initial begin
    FTk_t        x;
    logic        req, btk, prev_stall, prev_req;
    logic [15:0] addr;

    drive_idle();
    #2;
    chk_reset_vals("rst");
    #20;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Preload an image; boot words and a few directed targets override the pattern.
    for (int a = 0; a < 128; a++) init_wr(16'(a), 32'h1000 + 32'(a));
    for (int a = 0; a < 5; a++) init_wr(16'(a), 32'h11 + 32'(a));
    init_wr(16'd7, 32'h33);
    for (int a = 0; a < 3; a++) init_wr(16'(10 + a), 32'hA0 + 32'(a));

    // Boot: loads requested, backpressure toggled and stores attempted throughout.
    bt[0] = '{boot: 1, ld_req: 0, btk_n: 0, st_req: 1, exp_v: 0, exp_a: 0, exp_busy: 0,
              exp_stn: 1, exp_d: 0};
    for (int k = 1; k <= 8; k++)
      bt[k] = '{boot: 0, ld_req: 1, btk_n: (k == 3 || k == 4), st_req: 1, exp_v: 1,
                exp_a: (k == 1), exp_busy: 1, exp_stn: 1,
                exp_d: (k <= 3) ? 32'h0 : 32'h11 + 32'(k - 4)};
    bt[9] = '{boot: 0, ld_req: 0, btk_n: 0, st_req: 0, exp_v: 0, exp_a: 0, exp_busy: 0,
              exp_stn: 0, exp_d: 0};
    for (int e = 0; e < 10; e++) begin
      bus.I_Boot       = bt[e].boot;
      bus.I_Ld_Req     = bt[e].ld_req;
      bus.I_Ld_Addr    = 16'd5;
      bus.I_Ld_BTk     = '0;
      bus.I_Ld_BTk.n   = bt[e].btk_n;
      bus.I_St_Req     = bt[e].st_req;
      bus.I_St_Addr    = 16'd100;
      bus.I_St_FTk     = '0;
      bus.I_St_FTk.v   = 1'b1;
      bus.I_St_FTk.d   = 32'hDEAD;
      #1;
      if (bt[e].exp_v) begin
        x = '0;
        x.v = 1'b1;
        x.a = bt[e].exp_a;
        x.d = bt[e].exp_d;
        chk($sformatf("boot_tok%0d", e), 64'(bus.O_Ld_FTk), 64'(x));
      end else begin
        chk($sformatf("boot_v%0d", e), 64'(bus.O_Ld_FTk.v), 64'd0);
      end
      chk($sformatf("boot_busy%0d", e), 64'(bus.O_Busy), 64'(bt[e].exp_busy));
      chk($sformatf("boot_stn%0d", e), 64'(bus.O_St_BTk.n), 64'(bt[e].exp_stn));
      @(posedge clock);
      #1;
    end
    drive_idle();
    chk("boot_ldcnt", 64'(bus.O_Ld_Cnt), 64'd0);
    chk("boot_stcnt", 64'(bus.O_St_Cnt), 64'd0);

    // Back-to-back loads, responses RD_LAT later with the address as index.
    ld(16'd10, 1'b0);
    ld(16'd11, 1'b0);
    ld(16'd12, 1'b0);
    nop(4);

    // Four-cycle stall mid-stream with the request held.
    ld(16'd30, 1'b0);
    ld(16'd31, 1'b0);
    for (int k = 0; k < 4; k++) ld(16'd32, 1'b1);
    ld(16'd32, 1'b0);
    ld(16'd33, 1'b0);
    nop(4);

    // Same-cycle store and load to addr 7, then re-read; boot-time store must not have landed.
    cyc(1'b1, 16'd7, 1'b0, 1'b1, 1'b1, 16'd7, 32'h55, 1'b0, '0, '0);
    nop(1);
    ld(16'd7, 1'b0);
    ld(16'd100, 1'b0);
    nop(4);
    chk("st_cnt_one", 64'(bus.O_St_Cnt), 64'd1);

    // Store colliding with an init write is backpressured and dropped.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 16'd20, 32'hBAD, 1'b1, 16'd21, 32'h77);
    ld(16'd20, 1'b0);
    ld(16'd21, 1'b0);
    nop(4);

    // Out-of-range load and store.
    cyc(1'b1, 16'd2048, 1'b0, 1'b1, 1'b1, 16'd3000, 32'hEE, 1'b0, '0, '0);
    nop(4);
    chk("err_sticky", 64'(bus.O_Err), 64'd1);
    chk("oor_st_dropped", 64'(bus.O_St_Cnt), 64'd1);

    // Random traffic; a stalled requester keeps its request and address.
    prev_stall = 1'b0;
    prev_req   = 1'b0;
    addr       = '0;
    for (int n = 0; n < 400; n++) begin
      btk = ($urandom_range(0, 3) == 0);
      if (!(prev_stall && prev_req)) begin
        req  = 1'($urandom_range(0, 1));
        addr = ($urandom_range(0, 31) == 0) ? 16'(2048 + $urandom_range(0, 100))
                                            : 16'($urandom_range(0, 127));
      end
      cyc(req, addr, btk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom_range(0, 127)), $urandom, ($urandom_range(0, 7) == 0),
          16'($urandom_range(0, 127)), $urandom);
      prev_stall = btk;
      prev_req   = req;
    end

    // Asynchronous reset with loads in flight.
    ld(16'd5, 1'b0);
    ld(16'd6, 1'b0);
    drive_idle();
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    #1;
    reset = 1'b1;
    pend_q.delete();
    mdl_err    = 1'b0;
    mdl_ld_cnt = '0;
    mdl_st_cnt = '0;
    @(posedge clock);
    #1;

    // Reset in the middle of boot.
    bus.I_Boot = 1'b1;
    @(posedge clock);
    #1;
    bus.I_Boot = 1'b0;
    @(posedge clock);
    #1;
    chk("midboot_busy", 64'(bus.O_Busy), 64'd1);
    chk("midboot_v", 64'(bus.O_Ld_FTk.v), 64'd1);
    reset = 1'b0;
    #1;
    chk("midboot_rst_v", 64'(bus.O_Ld_FTk.v), 64'd0);
    chk("midboot_rst_busy", 64'(bus.O_Busy), 64'd0);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("after_rst_idle_busy", 64'(bus.O_Busy), 64'd0);
    chk("after_rst_idle_stn", 64'(bus.O_St_BTk.n), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
